program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Writer side of the instruction memory: receives a program as a byte stream over a valid/ready handshake, assembles big-endian 32-bit words and issues one write per word to the program memory write port.
- Holds the CPU (cpu_hold_o) for the whole load.
- Sits between a byte source (UART receiver or test bench) and the program memory.
- The write address is a byte address, word-aligned; the memory drops bits [1:0].

Parameters:
- MEMORY_DEPTH, 32: number of instruction words; maximum legal word count.
- DATA_WIDTH, 32: instruction/word width and address width; must be a multiple of 8.
- BASE_ADDRESS, 0: byte address of the first written word; must be 4-aligned.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start_i  input  1  begin a load; sampled in IDLE, DONE and ERROR
- byte_valid_i  input  1  byte_i holds a valid byte
- byte_i  input  8  stream byte
- byte_ready_o  output  1  loader accepts a byte this cycle
- wr_en_o  output  1  one-cycle write strobe to program memory
- wr_address_o  output  DATA_WIDTH  byte address of the word being written
- wr_data_o  output  DATA_WIDTH  assembled instruction word
- cpu_hold_o  output  1  keeps the processor in reset/stall while loading
- busy_o  output  1  load in progress
- done_o  output  1  level; last load completed successfully
- error_o  output  1  level; last load aborted on an illegal word count

Behaviour:
- Reset (asynchronous, reset=0):
  - state = IDLE.
  - All outputs 0; word/byte counters and assembly register cleared.
  - A reset mid-load stops writing immediately. Words already written stay in memory. No further wr_en_o pulses occur.
- Byte transfer occurs on a rising edge with byte_valid_i=1 and byte_ready_o=1. byte_i is ignored otherwise.
- Stream format:
  - First byte: word count N.
  - Then 4*N bytes, most significant byte of each word first.
- IDLE:
  - byte_ready_o=0.
  - start_i=1 -> COUNT.
- COUNT:
  - byte_ready_o=1.
  - On a transfer: if N==0 or N>MEMORY_DEPTH -> ERROR. Otherwise latch N, clear word_idx and byte_idx -> DATA.
- DATA:
  - byte_ready_o=1.
  - Each transfer: shift register = {shift[DATA_WIDTH-9:0], byte_i}; byte_idx++.
  - On the 4th byte of a word -> WRITE.
- WRITE (exactly one cycle):
  - byte_ready_o=0, wr_en_o=1.
  - wr_address_o = BASE_ADDRESS + 4*word_idx; wr_data_o = assembled word.
  - Then: if word_idx==N-1 -> DONE, else word_idx++ and -> DATA.
- Latency: the write strobe comes in the cycle after the 4th byte's accept edge.
- Peak rate: 4 bytes per 5 cycles.
- DONE:
  - done_o=1; byte_ready_o=0.
  - start_i=1 -> COUNT, clearing done_o.
- ERROR:
  - error_o=1; no writes issued.
  - start_i=1 -> COUNT, clearing error_o.
- Output levels:
  - busy_o = cpu_hold_o = 1 in COUNT, DATA and WRITE.
  - wr_address_o/wr_data_o are only meaningful while wr_en_o=1 and hold their last value otherwise.
- start_i is ignored in COUNT, DATA and WRITE.
- Stalls: byte_valid_i may drop at any point in DATA. There is no timeout, and partial word state is held.
- Width rules:
  - word_idx is $clog2(MEMORY_DEPTH)+1 bits wide, so N=MEMORY_DEPTH does not wrap.
  - The address add is DATA_WIDTH bits, modulo 2^DATA_WIDTH.

Decomposition:
- Package program_loader_pkg:
  - state encoding IDLE, COUNT, DATA, WRITE, DONE, ERROR.
  - BYTES_PER_WORD = DATA_WIDTH/8.
- Sub-module word_assembler:
  - Shift register plus byte counter.
  - Inputs: clk, reset, clear, shift_en, byte.
  - Outputs: word, word_full.
- The FSM, word counter and address generation stay in program_loader.

Test Plan:
- Reset asserted -> all outputs 0. Deassert and pulse start_i -> busy_o=cpu_hold_o=byte_ready_o=1.
- Stream 02, 20 08 00 05, 8C 09 00 04 with byte_valid_i held 1 -> wr_en_o pulses twice: (addr 0x0, data 0x20080005) and (addr 0x4, data 0x8C090004). done_o=1, busy_o=0, byte_ready_o=0.
- Same stream with byte_valid_i toggled every other cycle -> identical writes; wr_en_o is never high while byte_ready_o=1.
- Count byte 00, and separately count byte 21 with MEMORY_DEPTH=32 -> ERROR, error_o=1, zero wr_en_o pulses. A subsequent start_i and a valid stream -> success.
- N=32 with 128 bytes -> 32 writes, last at address 0x7C; done_o=1.
- Assert reset after the 2nd byte of word 1 in a 3-word load -> only word 0 written, all outputs 0 immediately. start_i then returns the block to COUNT.

Source files
------------

// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared FSM encoding and word-geometry helpers for the program loader.
package program_loader_pkg;
  typedef enum logic [2:0] {IDLE, COUNT, DATA, WRITE, DONE, ERROR} state_t;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int BYTES_PER_WORD = DEFAULT_DATA_WIDTH / 8;
  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction
endpackage

// File: rtl/program_loader_word_assembler.sv
// word_assembler: packs a big-endian byte stream into words and flags the byte that completes one.
module word_assembler
  import program_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  shift_en,
  input  logic [7:0]            data_byte,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_full
);
  localparam int BPW = bytes_per_word(DATA_WIDTH);
  localparam int CW = $clog2(BPW + 1);
  logic [DATA_WIDTH-9:0] shift;
  logic [CW-1:0] cnt;
  logic [DATA_WIDTH-1:0] next;
  assign next = {shift, data_byte};
  assign word_full = shift_en && cnt == CW'(BPW - 1);
  // word only updates on completion, so it holds the last written word between writes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift <= '0;
      cnt <= '0;
      word <= '0;
    end else if (clear) begin
      shift <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      shift <= next[DATA_WIDTH-9:0];
      cnt <= word_full ? '0 : cnt + CW'(1);
      if (word_full) word <= next;
    end
  end
endmodule

// File: rtl/program_loader.sv
// program_loader: loads a counted big-endian byte stream into program memory while holding the CPU.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BASE_ADDRESS = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  output logic                  byte_ready_o,
  output logic                  wr_en_o,
  output logic [DATA_WIDTH-1:0] wr_address_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  cpu_hold_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);
  localparam int BPW = bytes_per_word(DATA_WIDTH);
  localparam int WI = $clog2(MEMORY_DEPTH) + 1;
  state_t state;
  logic [WI-1:0] n;
  logic [WI-1:0] word_idx;
  logic xfer;
  logic bad_count;
  logic word_full;
  assign xfer = byte_valid_i && byte_ready_o;
  assign bad_count = byte_i == 8'd0 || 32'(byte_i) > MEMORY_DEPTH;
  word_assembler #(.DATA_WIDTH(DATA_WIDTH)) assembler (
    .clk(clk),
    .reset(reset),
    .clear(state == COUNT),
    .shift_en(xfer && state == DATA),
    .data_byte(byte_i),
    .word(wr_data_o),
    .word_full(word_full)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      n <= '0;
      word_idx <= '0;
      byte_ready_o <= 1'b0;
      wr_en_o <= 1'b0;
      wr_address_o <= '0;
      cpu_hold_o <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      error_o <= 1'b0;
    end else begin
      wr_en_o <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: if (start_i) begin
          state <= COUNT;
          byte_ready_o <= 1'b1;
          busy_o <= 1'b1;
          cpu_hold_o <= 1'b1;
          done_o <= 1'b0;
          error_o <= 1'b0;
        end
        COUNT: if (xfer) begin
          if (bad_count) begin
            state <= ERROR;
            error_o <= 1'b1;
            byte_ready_o <= 1'b0;
            busy_o <= 1'b0;
            cpu_hold_o <= 1'b0;
          end else begin
            state <= DATA;
            n <= WI'(byte_i);
            word_idx <= '0;
          end
        end
        DATA: if (word_full) begin
          state <= WRITE;
          byte_ready_o <= 1'b0;
          wr_en_o <= 1'b1;
          wr_address_o <= DATA_WIDTH'(BASE_ADDRESS) + DATA_WIDTH'(BPW) * DATA_WIDTH'(word_idx);
        end
        WRITE: if (word_idx == n - WI'(1)) begin
          state <= DONE;
          done_o <= 1'b1;
          busy_o <= 1'b0;
          cpu_hold_o <= 1'b0;
        end else begin
          state <= DATA;
          word_idx <= word_idx + WI'(1);
          byte_ready_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized and directed loads checked against a write-list model of the stream.
module tb_program_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_i = 1'b0;
  logic byte_valid_i = 1'b0;
  logic [7:0] byte_i = 8'h00;
  logic byte_ready_o, wr_en_o, cpu_hold_o, busy_o, done_o, error_o;
  logic [31:0] wr_address_o, wr_data_o;
  int compared = 0;
  int mismatched = 0;
  logic [31:0] act_addr[$];
  logic [31:0] act_data[$];
  logic [31:0] prog[$];

  always #5 clk = ~clk;

  program_loader #(.MEMORY_DEPTH(32), .DATA_WIDTH(32), .BASE_ADDRESS(0)) dut (
    .clk(clk),
    .reset(reset),
    .start_i(start_i),
    .byte_valid_i(byte_valid_i),
    .byte_i(byte_i),
    .byte_ready_o(byte_ready_o),
    .wr_en_o(wr_en_o),
    .wr_address_o(wr_address_o),
    .wr_data_o(wr_data_o),
    .cpu_hold_o(cpu_hold_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .error_o(error_o)
  );

  always @(negedge clk) begin
    if (wr_en_o) begin
      act_addr.push_back(wr_address_o);
      act_data.push_back(wr_data_o);
    end
    if (reset) begin
      compared++;
      assert (!(wr_en_o && byte_ready_o)) else begin
        mismatched++;
        $error("FAIL wr_vs_ready: wr_en_o=%b byte_ready_o=%b required not both 1", wr_en_o, byte_ready_o);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, 32'(byte_ready_o), 0);
    chk({tag, "_wr_en"}, 32'(wr_en_o), 0);
    chk({tag, "_hold"}, 32'(cpu_hold_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_done"}, 32'(done_o), 0);
    chk({tag, "_error"}, 32'(error_o), 0);
    chk({tag, "_addr"}, wr_address_o, 0);
    chk({tag, "_data"}, wr_data_o, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("start_busy", 32'(busy_o), 1);
    chk("start_hold", 32'(cpu_hold_o), 1);
    chk("start_ready", 32'(byte_ready_o), 1);
  endtask

  // gap < 0 picks a random 0..2 idle cycles before each byte
  task automatic send_byte(input logic [7:0] b, input int gap);
    int g;
    g = gap < 0 ? int'($urandom_range(2, 0)) : gap;
    repeat (g) begin
      @(negedge clk);
      byte_valid_i = 1'b0;
      byte_i = 8'($urandom);
    end
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      byte_valid_i = 1'b1;
      byte_i = b;
      if (byte_ready_o) begin
        @(posedge clk);
        return;
      end
    end
    chk("byte_timeout", 0, 1);
  endtask

  task automatic drop_valid();
    @(negedge clk);
    byte_valid_i = 1'b0;
    byte_i = 8'($urandom);
  endtask

  task automatic wait_end();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done_o || error_o) return;
    end
    chk("end_timeout", 0, 1);
  endtask

  task automatic run_load(input int gap);
    act_addr.delete();
    act_data.delete();
    pulse_start();
    send_byte(8'(prog.size()), gap);
    foreach (prog[i])
      for (int b = 3; b >= 0; b--) send_byte(prog[i][8*b +: 8], gap);
    drop_valid();
    wait_end();
    chk("n_writes", act_addr.size(), prog.size());
    foreach (prog[i]) begin
      if (i < act_addr.size()) begin
        chk($sformatf("addr[%0d]", i), act_addr[i], 32'(4 * i));
        chk($sformatf("data[%0d]", i), act_data[i], prog[i]);
      end
    end
    chk("ok_done", 32'(done_o), 1);
    chk("ok_error", 32'(error_o), 0);
    chk("ok_busy", 32'(busy_o), 0);
    chk("ok_hold", 32'(cpu_hold_o), 0);
    chk("ok_ready", 32'(byte_ready_o), 0);
  endtask

  task automatic run_bad(input logic [7:0] n);
    act_addr.delete();
    act_data.delete();
    pulse_start();
    send_byte(n, 0);
    drop_valid();
    wait_end();
    repeat (3) @(negedge clk);
    chk("bad_error", 32'(error_o), 1);
    chk("bad_done", 32'(done_o), 0);
    chk("bad_busy", 32'(busy_o), 0);
    chk("bad_ready", 32'(byte_ready_o), 0);
    chk("bad_writes", act_addr.size(), 0);
  endtask

  task automatic random_prog(input int n);
    prog.delete();
    repeat (n) prog.push_back($urandom);
  endtask

  initial begin
    #1 reset = 1'b0;
    #3 check_idle_outputs("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    prog = '{32'h20080005, 32'h8C090004};
    run_load(0);
    run_load(1);
    run_bad(8'h00);
    run_load(-1);
    run_bad(8'h21);
    run_bad(8'($urandom_range(255, 33)));
    random_prog(32);
    run_load(-1);
    random_prog(1);
    run_load(0);
    for (int r = 0; r < 3; r++) begin
      random_prog(int'($urandom_range(32, 1)));
      run_load(-1);
    end
    // abort a 3-word load after the second byte of word 1
    random_prog(3);
    act_addr.delete();
    act_data.delete();
    pulse_start();
    send_byte(8'd3, 0);
    for (int b = 3; b >= 0; b--) send_byte(prog[0][8*b +: 8], 0);
    send_byte(prog[1][31:24], 0);
    send_byte(prog[1][23:16], 0);
    #1 reset = 1'b0;
    #1 chk("abort_ready", 32'(byte_ready_o), 0);
    chk("abort_busy", 32'(busy_o), 0);
    chk("abort_hold", 32'(cpu_hold_o), 0);
    chk("abort_wr_en", 32'(wr_en_o), 0);
    drop_valid();
    repeat (4) @(negedge clk);
    chk("abort_writes", act_addr.size(), 1);
    if (act_addr.size() > 0) begin
      chk("abort_addr0", act_addr[0], 0);
      chk("abort_data0", act_data[0], prog[0]);
    end
    reset = 1'b1;
    pulse_start();
    random_prog(4);
    act_addr.delete();
    act_data.delete();
    send_byte(8'd4, 0);
    foreach (prog[i])
      for (int b = 3; b >= 0; b--) send_byte(prog[i][8*b +: 8], -1);
    drop_valid();
    wait_end();
    chk("recover_writes", act_addr.size(), 4);
    chk("recover_done", 32'(done_o), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
